ps2_scan_receiver: RTL
======================

// Module: ps2_scan_receiver
// PURPOSE
//  Upstream stage of the Keyboard port block. Deserializes PS/2 device-to-host frames from PS2_Clock/PS2_Data.
//  Drops key-release sequences (F0 xx), so downstream sees one make code per keypress.
//  Buffers make codes in a small FIFO with a valid/ack handshake toward the Port_ID/Read_Strobe register logic.
// PARAMETERS
//  CLK_FREQ_HZ   100_000_000  system clock frequency; sizes the timeout counter
//  FILTER_LEN    8            consecutive equal CLK samples needed to accept a PS2_Clock level change
//  TIMEOUT_US    1000         max gap between PS/2 falling edges inside a frame before abort
//  FIFO_DEPTH    4            make-code buffer entries (power of 2, >=2)
// PORTS
//  CLK          in   1  system clock, 100 MHz
//  RESET        in   1  asynchronous, active-low reset
//  PS2_Clock    in   1  raw PS/2 clock from pin, asynchronous
//  PS2_Data     in   1  raw PS/2 data from pin, asynchronous
//  Scan_Code    out  8  FIFO head make code; valid only while Scan_Valid=1
//  Scan_Valid   out  1  FIFO not empty
//  Scan_Ack     in   1  pop head on CLK edge when Scan_Valid=1; ignored when empty
//  Frame_Error  out  1  1-cycle pulse: bad start/stop/parity, or timeout
//  Overflow     out  1  1-cycle pulse: make code dropped because FIFO full
// BEHAVIOUR
//  Reset (RESET=0, async): FSM=IDLE, FIFO empty, break_pending=0.
//   All outputs 0; Scan_Code=8'h00. Filtered clock and data = 1.
//  Input path: 2-FF synchronizer on both pins, then FILTER_LEN glitch filter on the clock.
//   Sample event = filtered PS2_Clock 1->0. Data is sampled from the synchronized PS2_Data on that event.
//  FSM, advanced only on sample events:
//   IDLE   data=0 -> DATA, bit_cnt=0; data=1 -> Frame_Error pulse, stay IDLE
//   DATA   shift in LSB first; after 8th bit -> PARITY
//   PARITY capture bit -> STOP
//   STOP   data=1 -> frame done, -> IDLE
//          data=0 -> Frame_Error, discard, -> IDLE
//  Timeout: in any state but IDLE, TIMEOUT_US*CLK_FREQ_HZ/1e6 cycles without a sample event
//   -> Frame_Error, partial frame discarded, -> IDLE. Counter width = $clog2 of the limit.
//  Frame done, code classification:
//   F0           -> break_pending=1, nothing pushed
//   break_pending=1 -> code discarded, break_pending=0
//   otherwise (incl. E0) -> push code
//  Latency: Scan_Valid rises 2 CLK cycles after the stop-bit sample event (FIFO previously empty).
//  FIFO:
//   push while full -> code dropped, Overflow pulse, FIFO unchanged
//   push+pop same cycle -> both succeed, including when full and when holding 1 entry
//   pointers wrap modulo FIFO_DEPTH; occupancy counter is $clog2(FIFO_DEPTH)+1 bits
//   Scan_Code follows the new head the cycle after a pop
//  Frame_Error and Overflow in the same cycle: both pulse. Neither changes break_pending,
//   except a timeout, which clears it.
//  RESET asserted mid-frame: frame lost, FIFO flushed; the next start bit is received normally.
// CONFIGURATION
//  PS2_PARITY_CHECK_EN defined:
//   odd parity over 8 data bits + parity bit checked at STOP
//   mismatch -> Frame_Error, frame discarded, break_pending unaffected
//  PS2_PARITY_CHECK_EN undefined: parity bit captured and ignored; this is the default build
// STRUCTURE
//  Package ps2_pkg:
//   FSM state enum {IDLE, DATA, PARITY, STOP}
//   constants PS2_BREAK_CODE=8'hF0, PS2_EXT_CODE=8'hE0, PS2_FRAME_BITS=11
//  Sub-module ps2_input_filter: 2-FF synchronizers, FILTER_LEN glitch filter, falling-edge pulse
//   outputs: sample_evt, data_s
//  FSM, classifier and FIFO stay inline in ps2_scan_receiver.
// TESTING (PS/2 half-period 30 us, CLK 100 MHz)
//  1. Frame 78, then F0, then 78 (parity 0, stop 1)
//     -> exactly one push of 8'h78; Scan_Valid=1; Scan_Code=8'h78; no Frame_Error
//  2. Sequence 05, 0D, 1E with no Scan_Ack -> FIFO holds 05,0D,1E in order
//     Then 3 acks in consecutive cycles -> Scan_Code 05,0D,1E; Scan_Valid=0 after the 3rd
//  3. 5 make codes 16 with FIFO_DEPTH=4 and no ack -> 4 stored, 1 Overflow pulse
//     Then ack+push in the same cycle at full -> occupancy stays 4
//  4. Frame stops after 4 data bits, idle 1.2 ms
//     -> Frame_Error at 1 ms after the last edge; then frame 5A -> Scan_Code=8'h5A
//  5. Stop bit=0 on frame 1E -> Frame_Error, nothing pushed
//     With PS2_PARITY_CHECK_EN, frame 5A with parity 0 -> Frame_Error; with parity 1 -> push 5A
//  6. RESET low for 50 ns in the middle of DATA
//     -> all outputs 0, FIFO empty; next complete frame 0D -> push 0D

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 scan-code receiver.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } ps2_state_e;

    localparam logic [7:0]  PS2_BREAK_CODE = 8'hF0;
    localparam logic [7:0]  PS2_EXT_CODE   = 8'hE0;
    localparam int unsigned PS2_FRAME_BITS = 11;

    // Odd parity holds when data plus parity bit carry an odd number of ones.
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/ps2_input_filter.sv
// Pin conditioning for PS/2: 2-FF synchronizers, glitch filter on the clock line,
// and a one-cycle pulse on each filtered clock falling edge.
module ps2_input_filter #(
    parameter int unsigned FILTER_LEN = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ps2_clk,
    input  logic ps2_data,
    output logic sample_evt,
    output logic data_s
);

    localparam int unsigned CNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

    logic [1:0]       clk_sync;
    logic [1:0]       data_sync;
    logic [CNT_W-1:0] cnt;
    logic             clk_filt;

    // A new clock level is accepted only after FILTER_LEN consecutive agreeing samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_sync   <= 2'b11;
            data_sync  <= 2'b11;
            cnt        <= '0;
            clk_filt   <= 1'b1;
            sample_evt <= 1'b0;
        end else begin
            clk_sync   <= {clk_sync[0], ps2_clk};
            data_sync  <= {data_sync[0], ps2_data};
            sample_evt <= 1'b0;
            if (clk_sync[1] != clk_filt) begin
                if (cnt == CNT_W'(FILTER_LEN - 1)) begin
                    clk_filt   <= clk_sync[1];
                    cnt        <= '0;
                    sample_evt <= clk_filt;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

    assign data_s = data_sync[1];

endmodule

// File: rtl/ps2_scan_receiver.sv
// PS/2 device-to-host receiver: frame deserializer, break-sequence filter and make-code FIFO.
// Optional build macro PS2_PARITY_CHECK_EN enables odd-parity checking of each frame.
module ps2_scan_receiver
    import ps2_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ = 100_000_000,
    parameter int unsigned FILTER_LEN  = 8,
    parameter int unsigned TIMEOUT_US  = 1000,
    parameter int unsigned FIFO_DEPTH  = 4
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       PS2_Clock,
    input  logic       PS2_Data,
    output logic [7:0] Scan_Code,
    output logic       Scan_Valid,
    input  logic       Scan_Ack,
    output logic       Frame_Error,
    output logic       Overflow
);

    localparam longint unsigned TO_LIMIT  = 64'(TIMEOUT_US) * 64'(CLK_FREQ_HZ) / 64'd1_000_000;
    localparam int unsigned     TO_W      = $clog2(TO_LIMIT);
    localparam logic [TO_W-1:0] TO_LAST   = TO_W'(TO_LIMIT - 64'd1);
    localparam int unsigned     PW        = $clog2(FIFO_DEPTH);
    localparam int unsigned     CW        = PW + 1;
    localparam int unsigned     DATA_BITS = PS2_FRAME_BITS - 3;

`ifdef PS2_PARITY_CHECK_EN
    localparam bit PARITY_EN = 1'b1;
`else
    localparam bit PARITY_EN = 1'b0;
`endif

    logic            sample_evt;
    logic            data_s;
    ps2_state_e      state;
    logic [2:0]      bit_cnt;
    logic [7:0]      shreg;
    logic            parity_bit;
    logic            break_pending;
    logic            push_req;
    logic [7:0]      push_code;
    logic [TO_W-1:0] to_cnt;
    logic            timeout_c;
    logic            frame_bad_c;

    logic [7:0]      mem [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic            do_push_c;
    logic            do_pop_c;
    logic [CW-1:0]   count_nxt_c;
    logic [PW-1:0]   rd_nxt_c;
    logic [7:0]      head_nxt_c;

    ps2_input_filter #(
        .FILTER_LEN (FILTER_LEN)
    ) u_filter (
        .clk        (CLK),
        .rst_n      (RESET),
        .ps2_clk    (PS2_Clock),
        .ps2_data   (PS2_Data),
        .sample_evt (sample_evt),
        .data_s     (data_s)
    );

    assign timeout_c   = (state != IDLE) && !sample_evt && (to_cnt == TO_LAST);
    assign frame_bad_c = !data_s || (PARITY_EN && !odd_parity_ok(shreg, parity_bit));

    // Inter-edge watchdog; only runs while a frame is in progress.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            to_cnt <= '0;
        end else if ((state == IDLE) || sample_evt) begin
            to_cnt <= '0;
        end else if (!timeout_c) begin
            to_cnt <= to_cnt + 1'b1;
        end
    end

    // Frame FSM plus make/break classification; a finished make code becomes a push request.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state         <= IDLE;
            bit_cnt       <= '0;
            shreg         <= '0;
            parity_bit    <= 1'b0;
            break_pending <= 1'b0;
            push_req      <= 1'b0;
            push_code     <= '0;
            Frame_Error   <= 1'b0;
        end else begin
            Frame_Error <= 1'b0;
            push_req    <= 1'b0;
            if (timeout_c) begin
                state         <= IDLE;
                Frame_Error   <= 1'b1;
                break_pending <= 1'b0;
            end else if (sample_evt) begin
                case (state)
                    IDLE: begin
                        if (!data_s) begin
                            state   <= DATA;
                            bit_cnt <= '0;
                        end else begin
                            Frame_Error <= 1'b1;
                        end
                    end
                    DATA: begin
                        shreg   <= {data_s, shreg[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'(DATA_BITS - 1)) state <= PARITY;
                    end
                    PARITY: begin
                        parity_bit <= data_s;
                        state      <= STOP;
                    end
                    STOP: begin
                        state <= IDLE;
                        if (frame_bad_c) begin
                            Frame_Error <= 1'b1;
                        end else if (shreg == PS2_BREAK_CODE) begin
                            break_pending <= 1'b1;
                        end else if (break_pending) begin
                            break_pending <= 1'b0;
                        end else begin
                            push_req  <= 1'b1;
                            push_code <= shreg;
                        end
                    end
                endcase
            end
        end
    end

    // FIFO next state; a pop frees the slot a simultaneous push needs when full.
    always_comb begin
        do_pop_c    = Scan_Ack && (count != '0);
        do_push_c   = push_req && ((count != CW'(FIFO_DEPTH)) || do_pop_c);
        count_nxt_c = count + CW'(do_push_c) - CW'(do_pop_c);
        rd_nxt_c    = do_pop_c ? rd_ptr + 1'b1 : rd_ptr;
        head_nxt_c  = mem[rd_nxt_c];
        if (count_nxt_c == '0) begin
            head_nxt_c = '0;
        end else if (do_push_c && (rd_nxt_c == wr_ptr)) begin
            head_nxt_c = push_code;
        end
    end

    always_ff @(posedge CLK) begin
        if (do_push_c) mem[wr_ptr] <= push_code;
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            Scan_Valid <= 1'b0;
            Scan_Code  <= '0;
            Overflow   <= 1'b0;
        end else begin
            if (do_push_c) wr_ptr <= wr_ptr + 1'b1;
            rd_ptr     <= rd_nxt_c;
            count      <= count_nxt_c;
            Scan_Valid <= (count_nxt_c != '0);
            Scan_Code  <= head_nxt_c;
            Overflow   <= push_req && !do_push_c;
        end
    end

endmodule
